// File: rtl/iir_out_requant.sv
// Output stage for the time-multiplexed IIR: once-per-frame capture, round/saturate
// from Q(WIO).(WFO) to Q(WIR).(WFR), then a show-ahead FIFO with valid/ready output.
module iir_out_requant #(
    parameter int unsigned NUMBER    = 4,
    parameter int unsigned WIO       = 23,
    parameter int unsigned WFO       = 44,
    parameter int unsigned WIR       = 5,
    parameter int unsigned WFR       = 11,
    parameter int unsigned CAP_PHASE = 3,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       CE,
    input  logic                       we,
    input  logic [WIO+WFO-1:0]         din,
    output logic [WIR+WFR-1:0]         dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       sat_flag,
    output logic [15:0]                sat_count,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned WI = WIO + WFO;
    localparam int unsigned WS = WI + 1;
    localparam int unsigned WR = WIR + WFR;
    localparam int unsigned SH = WFO - WFR;
    localparam int unsigned PW = (NUMBER > 1) ? $clog2(NUMBER) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    localparam logic signed [WS-1:0] HALF = {{(WS-1){1'b0}}, 1'b1} << (SH - 1);
    localparam logic signed [WS-1:0] QMAX = {{(WS-WR+1){1'b0}}, {(WR-1){1'b1}}};
    localparam logic signed [WS-1:0] QMIN = ~QMAX;
    localparam logic [WR-1:0]        SATP = {1'b0, {(WR-1){1'b1}}};
    localparam logic [WR-1:0]        SATN = {1'b1, {(WR-1){1'b0}}};

    logic [PW-1:0]  phase_q, phase_d;
    logic           v1_q, v1_d;
    logic [WI-1:0]  din_q, din_d;
    logic           v2_q, v2_d;
    logic [WR-1:0]  res_q, res_d;
    logic           sat_flag_q, sat_flag_d;
    logic [15:0]    sat_count_q, sat_count_d;
    logic [15:0]    drop_count_q, drop_count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [WR-1:0]  last_q, last_d;
    logic [WR-1:0]  mem_q [DEPTH];

    logic                 cap;
    logic signed [WS-1:0] sum;
    logic signed [WS-1:0] q;
    logic [WR-1:0]        rq;
    logic                 sat;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    always_comb begin
        phase_d = phase_q;
        if (!we) begin
            phase_d = '0;
        end else if (CE) begin
            phase_d = (phase_q == PW'(NUMBER - 1)) ? '0 : phase_q + PW'(1);
        end
        cap   = we & CE & (phase_q == PW'(CAP_PHASE));
        v1_d  = cap;
        din_d = cap ? din : din_q;
    end

    // Round half toward +inf, then clamp to the signed output range.
    always_comb begin
        sum = $signed({din_q[WI-1], din_q}) + HALF;
        q   = sum >>> SH;
        sat = 1'b0;
        rq  = q[WR-1:0];
        if (q > QMAX) begin
            rq  = SATP;
            sat = 1'b1;
        end else if (q < QMIN) begin
            rq  = SATN;
            sat = 1'b1;
        end
        v2_d        = v1_q;
        res_d       = v1_q ? rq : res_q;
        sat_flag_d  = sat_flag_q | (v1_q & sat);
        sat_count_d = sat_count_q;
        if (v1_q && sat && sat_count_q != 16'hFFFF) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        pop          = (level_q != '0) & dout_ready;
        push         = v2_q & (~full | pop);
        drop         = v2_q & full & ~pop;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        last_d       = pop ? mem_q[rd_ptr_q] : last_q;
        level_d      = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            phase_q      <= '0;
            v1_q         <= 1'b0;
            din_q        <= '0;
            v2_q         <= 1'b0;
            res_q        <= '0;
            sat_flag_q   <= 1'b0;
            sat_count_q  <= '0;
            drop_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            last_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            v1_q         <= v1_d;
            din_q        <= din_d;
            v2_q         <= v2_d;
            res_q        <= res_d;
            sat_flag_q   <= sat_flag_d;
            sat_count_q  <= sat_count_d;
            drop_count_q <= drop_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            last_q       <= last_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset && push) begin
            mem_q[wr_ptr_q] <= res_q;
        end
    end

    assign dout       = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign dout_valid = (level_q != '0);
    assign sat_flag   = sat_flag_q;
    assign sat_count  = sat_count_q;
    assign drop_count = drop_count_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_iir_out_requant.sv
// Self-checking bench for iir_out_requant: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_iir_out_requant;

    localparam int NUMBER = 4;
    localparam int CAP    = 3;
    localparam int DEPTH  = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        CE = 1'b0;
    logic        we = 1'b0;
    logic [66:0] din = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        sat_flag;
    logic [15:0] sat_count;
    logic [15:0] drop_count;
    logic [2:0]  fifo_level;

    iir_out_requant dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .CE         (CE),
        .we         (we),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: floor(x / 2^33 + 1/2), clamped to 16-bit signed. Bit 16 = saturated.
    function automatic logic [16:0] requant(input logic [66:0] x);
        logic signed [127:0] n, d, qq, m;
        n  = 128'($signed(x));
        n  = n + (128'sd1 <<< 32);
        d  = 128'sd1 <<< 33;
        qq = n / d;
        m  = n % d;
        if (n < 0 && m != 0) qq = qq - 1;
        if (qq > 32767) return {1'b1, 16'h7FFF};
        if (qq < -32768) return {1'b1, 16'h8000};
        return {1'b0, qq[15:0]};
    endfunction

    int          m_ph;
    bit          m_cv, m_sv, m_sflag;
    logic [66:0] m_cval;
    logic [15:0] m_sval, m_last;
    logic [15:0] mq[$];
    int          m_scnt, m_dcnt;

    task automatic model_reset();
        mq.delete();
        m_ph = 0; m_cv = 0; m_sv = 0; m_sflag = 0;
        m_cval = '0; m_sval = '0; m_last = '0;
        m_scnt = 0; m_dcnt = 0;
    endtask

    // Advance the model on the current inputs, clock once, then compare every output.
    task automatic step();
        logic [16:0] r;
        if (Reset) begin
            model_reset();
        end else begin
            if (mq.size() > 0 && dout_ready) m_last = mq.pop_front();
            if (m_sv) begin
                if (mq.size() < DEPTH) mq.push_back(m_sval);
                else if (m_dcnt < 65535) m_dcnt++;
            end
            r = requant(m_cval);
            m_sv = m_cv;
            m_sval = r[15:0];
            if (m_cv && r[16]) begin
                m_sflag = 1;
                if (m_scnt < 65535) m_scnt++;
            end
            m_cv = we && CE && (m_ph == CAP);
            m_cval = din;
            if (!we) m_ph = 0;
            else if (CE) m_ph = (m_ph + 1) % NUMBER;
        end
        @(posedge CLK);
        #1;
        chk("valid", dout_valid, mq.size() > 0);
        chk("dout", dout, (mq.size() > 0) ? mq[0] : m_last);
        chk("level", fifo_level, mq.size());
        chk("sat_flag", sat_flag, m_sflag);
        chk("sat_count", sat_count, m_scnt);
        chk("drop_count", drop_count, m_dcnt);
    endtask

    task automatic do_reset();
        Reset = 1;
        step();
        Reset = 0;
    endtask

    task automatic run_until_capture();
        bit ok = 0;
        for (int i = 0; i < 16 && !ok; i++) begin
            step();
            ok = m_cv;
        end
        chk("capture_timeout", ok, 1);
    endtask

    typedef struct {
        logic [66:0] din;
        logic [15:0] exp;
        int          scnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        logic [63:0] r64;
        logic [95:0] r96;
        int s;

        vecs[0] = '{67'sd1 <<< 44,           16'h0800, 0};
        vecs[1] = '{67'sd1 <<< 32,           16'h0001, 0};
        vecs[2] = '{-(67'sd1 <<< 32),        16'h0000, 0};
        vecs[3] = '{-(67'sd3 <<< 32),        16'hFFFF, 0};
        vecs[4] = '{67'sd100 <<< 44,         16'h7FFF, 1};
        vecs[5] = '{-(67'sd20 <<< 44),       16'h8000, 2};
        vecs[6] = '{-(67'sd16 <<< 44),       16'h8000, 2};

        model_reset();
        step();
        do_reset();
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", fifo_level, 0);

        // Directed vectors, one frame each, consumer always ready.
        we = 1; CE = 1; dout_ready = 1;
        foreach (vecs[i]) begin
            din = vecs[i].din;
            run_until_capture();
            din = {3'b101, {16{4'hA}}};
            step();
            chk("vec_early_valid", dout_valid, 0);
            step();
            chk("vec_valid", dout_valid, 1);
            chk("vec_dout", dout, vecs[i].exp);
            chk("vec_sat_count", sat_count, vecs[i].scnt);
            chk("vec_sat_flag", sat_flag, vecs[i].scnt > 0);
        end

        // Reset one clock after a capture: the in-flight sample must vanish.
        din = 67'sd1 <<< 44;
        run_until_capture();
        Reset = 1;
        step();
        Reset = 0; we = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_flight_valid", dout_valid, 0);
        end
        chk("rst_flight_sat_flag", sat_flag, 0);
        chk("rst_flight_sat_count", sat_count, 0);
        chk("rst_flight_drop", drop_count, 0);
        chk("rst_flight_dout", dout, 0);

        // Back-pressure: 6 frames into a 4-deep FIFO, then drain.
        do_reset();
        we = 1; CE = 1; dout_ready = 0;
        for (int k = 0; k < 6; k++) begin
            din = 67'(k + 1) <<< 33;
            run_until_capture();
        end
        step();
        step();
        chk("bp_level", fifo_level, 4);
        chk("bp_drop", drop_count, 2);
        we = 0; dout_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", dout_valid, 1);
            chk("bp_drain_dout", dout, k + 1);
            step();
        end
        chk("bp_empty", dout_valid, 0);
        chk("bp_hold_dout", dout, 4);

        // Full FIFO with a pop in the same cycle as the write.
        do_reset();
        we = 1; CE = 1; dout_ready = 0;
        for (int k = 0; k < 5; k++) begin
            din = 67'(k + 1) <<< 33;
            run_until_capture();
        end
        step();
        chk("full_level_before", fifo_level, 4);
        dout_ready = 1;
        step();
        dout_ready = 0;
        chk("full_level_after", fifo_level, 4);
        chk("full_drop", drop_count, 0);
        we = 0; dout_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("full_order", dout, k + 2);
            step();
        end
        chk("full_empty", dout_valid, 0);

        // CE held low for three clocks delays the capture by exactly three clocks.
        do_reset();
        we = 1; CE = 0; dout_ready = 1; din = 67'sd3 <<< 33;
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cyc++;
        end
        CE = 1;
        for (int i = 0; i < 20 && !dout_valid; i++) begin
            step();
            cyc++;
        end
        chk("ce_latency", cyc, 9);
        chk("ce_dout", dout, 3);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            CE = ($urandom_range(9) < 8);
            we = ($urandom_range(19) != 0);
            dout_ready = $urandom_range(1);
            Reset = ($urandom_range(499) == 0);
            case ($urandom_range(3))
                0: begin
                    r64 = {$urandom, $urandom};
                    din = {{18{r64[48]}}, r64[48:0]};
                end
                1: begin
                    r96 = {$urandom, $urandom, $urandom};
                    din = r96[66:0];
                end
                2: din = $urandom_range(1) ? (67'sd16 <<< 44) - 67'($urandom_range(1) << 32)
                                           : -(67'sd16 <<< 44) - 67'($urandom_range(1) << 32);
                default: begin
                    s = int'($urandom_range(255)) - 128;
                    din = 67'(s) <<< 32;
                end
            endcase
            step();
        end
        Reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
